// File: rtl/execute_mc.sv
// execute_mc: registered execute stage for the WISC pipeline.
//
// Purpose
//   Consumes one decoded instruction per input handshake and produces one
//   registered {result, next_pc, taken} record per output handshake.
//   Ops 0-12 and 14/15 (divider disabled) complete in one cycle. MUL always
//   runs an iterative shift-add unit. With EXECUTE_MC_DIV_EN defined, DIVU
//   and REMU run an iterative restoring divider. Both units take WIDTH
//   iterations and write the record WIDTH+1 edges after the accept edge.
//
// Handshake
//   Input:  an instruction transfers on a rising edge where in_valid and
//           in_ready are both 1. in_valid must not depend on in_ready.
//   Output: a record transfers on a rising edge where out_valid and
//           out_ready are both 1. While out_valid=1 and out_ready=0 the
//           record is held stable and in_ready stays 0.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  input handshake
//   op, a, b, imm       opcode and operands (B = alu_src ? b : imm)
//   alu_src             operand-B select
//   inc_pc              PC+2 of the instruction
//   branch, br_cond     conditional branch and its condition on a
//   jump, jump_reg      PC-relative jump, register jump
//   out_valid, out_ready output handshake
//   result, next_pc, taken registered record
//   busy                multi-cycle op in progress
//   fsm_state           debug view of the FSM state (0 IDLE, 1 MUL, 2 DIV)
//
// Configuration
//   EXECUTE_MC_DIV_EN   defined: DIVU/REMU use the multi-cycle divider.
//                       undefined: DIVU/REMU return 0 in a single cycle.

module execute_mc #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] imm,
    input  logic             alu_src,
    input  logic [WIDTH-1:0] inc_pc,
    input  logic             branch,
    input  logic [1:0]       br_cond,
    input  logic             jump,
    input  logic             jump_reg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] next_pc,
    output logic             taken,
    output logic             busy,
    output logic [1:0]       fsm_state
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_ANDN = 4'd3;
    localparam logic [3:0] OP_ROL  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_ROR  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_SEQ  = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_SLE  = 4'd10;
    localparam logic [3:0] OP_SCO  = 4'd11;
    localparam logic [3:0] OP_BTR  = 4'd12;
    localparam logic [3:0] OP_MUL  = 4'd13;
`ifdef EXECUTE_MC_DIV_EN
    localparam logic [3:0] OP_DIVU = 4'd14;
    localparam logic [3:0] OP_REMU = 4'd15;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef EXECUTE_MC_DIV_EN
        ST_DIV  = 2'd2,
`endif
        ST_MUL  = 2'd1
    } state_t;

    state_t state;

    // Shared iterative datapath. MUL: acc = partial product, mcand shifts
    // left, mplier shifts right. DIV: acc = partial remainder, mplier holds
    // the dividend and collects quotient bits, mcand holds the divisor.
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    iter;
`ifdef EXECUTE_MC_DIV_EN
    logic             rem_sel;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
`endif

    logic [WIDTH-1:0]   opb;
    logic [SW-1:0]      sh;
    logic [2*WIDTH-1:0] rot_l;
    logic [2*WIDTH-1:0] rot_r;
    logic [WIDTH:0]     sum_c;
    logic [WIDTH-1:0]   bit_rev;
    logic [WIDTH-1:0]   alu_res;
    logic               multi_op;
    logic               cond_true;
    logic               redirect;
    logic               tk;
    logic [WIDTH-1:0]   pc_next;
    logic               accept;

    assign in_ready  = (state == ST_IDLE) & (~out_valid | out_ready);
    assign accept    = in_valid & in_ready;
    assign fsm_state = state;

    always_comb begin
        opb   = alu_src ? b : imm;
        sh    = opb[SW-1:0];
        // Rotates shift a doubled copy of A so the wrapped bits fall in.
        rot_l = {a, a} << sh;
        rot_r = {a, a} >> sh;
        sum_c = {1'b0, a} + {1'b0, opb};
        for (int i = 0; i < WIDTH; i++) begin
            bit_rev[i] = a[WIDTH-1-i];
        end

        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = sum_c[WIDTH-1:0];
            OP_SUB:  alu_res = opb - a;
            OP_XOR:  alu_res = a ^ opb;
            OP_ANDN: alu_res = a & ~opb;
            OP_ROL:  alu_res = rot_l[2*WIDTH-1:WIDTH];
            OP_SLL:  alu_res = a << sh;
            OP_ROR:  alu_res = rot_r[WIDTH-1:0];
            OP_SRL:  alu_res = a >> sh;
            OP_SEQ:  alu_res = {{(WIDTH-1){1'b0}}, a == opb};
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) <  $signed(opb)};
            OP_SLE:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) <= $signed(opb)};
            OP_SCO:  alu_res = {{(WIDTH-1){1'b0}}, sum_c[WIDTH]};
            OP_BTR:  alu_res = bit_rev;
            default: alu_res = '0;
        endcase

`ifdef EXECUTE_MC_DIV_EN
        multi_op = (op == OP_MUL) | (op == OP_DIVU) | (op == OP_REMU);
        // One restoring step: bring in the next dividend bit, subtract the
        // divisor if it fits. A zero divisor always "fits", which yields an
        // all-ones quotient and leaves the dividend as the remainder.
        div_sh   = {acc, mplier[WIDTH-1]};
        div_diff = div_sh - {1'b0, mcand};
        div_ge   = div_sh >= {1'b0, mcand};
`else
        multi_op = (op == OP_MUL);
`endif

        case (br_cond)
            2'b00:   cond_true = (a == '0);
            2'b01:   cond_true = (a != '0);
            2'b10:   cond_true = a[WIDTH-1];
            default: cond_true = ~a[WIDTH-1];
        endcase
        redirect = jump | (branch & cond_true);
        tk       = jump_reg | redirect;
        if (jump_reg) begin
            pc_next = a + imm;
        end else if (redirect) begin
            pc_next = inc_pc + imm;
        end else begin
            pc_next = inc_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            next_pc   <= '0;
            taken     <= 1'b0;
            busy      <= 1'b0;
            iter      <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
`ifdef EXECUTE_MC_DIV_EN
            rem_sel   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        // PC resolution is captured at accept for every op;
                        // out_valid is low for multi-cycle ops until done.
                        next_pc <= pc_next;
                        taken   <= tk;
                        if (multi_op) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b1;
                            iter      <= '0;
                            acc       <= '0;
`ifdef EXECUTE_MC_DIV_EN
                            rem_sel   <= (op == OP_REMU);
                            if (op == OP_MUL) begin
                                mcand  <= a;
                                mplier <= opb;
                                state  <= ST_MUL;
                            end else begin
                                mcand  <= opb;
                                mplier <= a;
                                state  <= ST_DIV;
                            end
`else
                            mcand     <= a;
                            mplier    <= opb;
                            state     <= ST_MUL;
`endif
                        end else begin
                            out_valid <= 1'b1;
                            result    <= alu_res;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end

                ST_MUL: begin
                    if (iter == LAST_ITER) begin
                        result    <= acc;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        if (mplier[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        iter   <= iter + 1'b1;
                    end
                end

`ifdef EXECUTE_MC_DIV_EN
                ST_DIV: begin
                    if (iter == LAST_ITER) begin
                        result    <= rem_sel ? acc : mplier;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        acc    <= div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
                        mplier <= {mplier[WIDTH-2:0], div_ge};
                        iter   <= iter + 1'b1;
                    end
                end
`endif

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_execute_mc.sv
module tb_execute_mc;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a, b, imm, inc_pc;
    logic         alu_src, branch, jump, jump_reg;
    logic [1:0]   br_cond;
    logic         out_valid, out_ready;
    logic [W-1:0] result, next_pc;
    logic         taken, busy;
    logic [1:0]   fsm_state;

    int checks   = 0;
    int failures = 0;

    logic [2*W:0] exp_q[$];
    logic [2*W:0] sb_exp;
    logic         rand_mode = 1'b0;

    execute_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .imm(imm), .alu_src(alu_src), .inc_pc(inc_pc),
        .branch(branch), .br_cond(br_cond), .jump(jump), .jump_reg(jump_reg),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .next_pc(next_pc), .taken(taken), .busy(busy), .fsm_state(fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] model_alu(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] r;
        int amt;
        amt = int'(y[3:0]);
        r = '0;
        case (o)
            4'd0:  r = x + y;
            4'd1:  r = y - x;
            4'd2:  r = x ^ y;
            4'd3:  r = x & ~y;
            4'd4:  begin r = x; for (int i = 0; i < amt; i++) r = {r[W-2:0], r[W-1]}; end
            4'd5:  r = x << amt;
            4'd6:  begin r = x; for (int i = 0; i < amt; i++) r = {r[0], r[W-1:1]}; end
            4'd7:  r = x >> amt;
            4'd8:  r = (x == y) ? 16'd1 : 16'd0;
            4'd9:  r = ((x ^ 16'h8000) <  (y ^ 16'h8000)) ? 16'd1 : 16'd0;
            4'd10: r = ((x ^ 16'h8000) <= (y ^ 16'h8000)) ? 16'd1 : 16'd0;
            4'd11: r = ((int'(x) + int'(y)) > 65535) ? 16'd1 : 16'd0;
            4'd12: for (int i = 0; i < W; i++) r[i] = x[W-1-i];
            4'd13: begin int p; p = int'(x) * int'(y); r = p[W-1:0]; end
`ifdef EXECUTE_MC_DIV_EN
            4'd14: r = (y == 0) ? 16'hFFFF : x / y;
            4'd15: r = (y == 0) ? x : x % y;
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [W:0] model_pc(input logic [W-1:0] x, input logic [W-1:0] im, input logic [W-1:0] pc,
                                            input logic br, input logic [1:0] bc, input logic j, input logic jr);
        logic c;
        case (bc)
            2'b00: c = (x == 0);
            2'b01: c = (x != 0);
            2'b10: c = (x >= 16'h8000);
            default: c = (x < 16'h8000);
        endcase
        if (jr) return {1'b1, x + im};
        if (j || (br && c)) return {1'b1, pc + im};
        return {1'b0, pc};
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected got taken=%b next_pc=%h result=%h required no record", taken, next_pc, result);
            end else begin
                sb_exp = exp_q.pop_front();
                if ({taken, next_pc, result} !== sb_exp) begin
                    failures++;
                    $display("FAIL sb_record got taken=%b next_pc=%h result=%h required taken=%b next_pc=%h result=%h",
                             taken, next_pc, result, sb_exp[2*W], sb_exp[2*W-1:W], sb_exp[W-1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_inputs(input logic [3:0] o, input logic [W-1:0] av, input logic [W-1:0] bv, input logic [W-1:0] iv,
                              input logic src, input logic [W-1:0] pc, input logic br, input logic [1:0] bc,
                              input logic j, input logic jr);
        op = o; a = av; b = bv; imm = iv; alu_src = src; inc_pc = pc;
        branch = br; br_cond = bc; jump = j; jump_reg = jr;
    endtask

    // Presents one instruction, optionally pushes its expected record, and
    // returns at #1 after the accept edge. waits = cycles spent stalled.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] av, input logic [W-1:0] bv, input logic [W-1:0] iv,
                         input logic src, input logic [W-1:0] pc, input logic br, input logic [1:0] bc,
                         input logic j, input logic jr, input logic do_push, input logic [W-1:0] er,
                         input logic [W-1:0] en, input logic et, output int waits);
        bit got;
        set_inputs(o, av, bv, iv, src, pc, br, bc, j, jr);
        in_valid = 1'b1;
        if (do_push) exp_q.push_back({et, en, er});
        got = 0;
        waits = 0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                got = 1;
            end else begin
                @(posedge clk); #1;
                waits++;
                if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL accept_timeout got in_ready=%b required 1 within 200 cycles", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic alu_op(input logic [3:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] iv, input logic src, input logic [W-1:0] er);
        int w;
        issue(o, av, bv, iv, src, 16'h0200, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, er, 16'h0200, 1'b0, w);
    endtask

    task automatic wait_drain();
        out_ready = 1'b1;
        for (int c = 0; c < 300 && exp_q.size() != 0; c++) @(posedge clk);
        @(posedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout got pending=%0d required 0", exp_q.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_inputs(4'd0, '0, '0, '0, 1'b1, '0, 1'b0, 2'b00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, busy, taken} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got out_valid=%b busy=%b taken=%b required 000", out_valid, busy, taken);
        end
        checks++;
        if ({result, next_pc} !== 32'h0) begin
            failures++;
            $display("FAIL reset_regs got result=%h next_pc=%h required 0000 0000", result, next_pc);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || fsm_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_ready got in_ready=%b state=%0d required 1 0", in_ready, fsm_state);
        end
    endtask

    task automatic test_alu();
        int w;
        // Latency: record visible right after the accept edge.
        issue(4'd0, 16'h7FFF, 16'h0001, 16'h0, 1'b1, 16'h0200, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 16'h8000, 16'h0200, 1'b0, w);
        checks++;
        if (out_valid !== 1'b1 || result !== 16'h8000) begin
            failures++;
            $display("FAIL add_latency got out_valid=%b result=%h required 1 8000", out_valid, result);
        end
        alu_op(4'd11, 16'h7FFF, 16'h0001, 16'h0, 1'b1, 16'h0000);
        alu_op(4'd11, 16'hFFFF, 16'h0001, 16'h0, 1'b1, 16'h0001);
        alu_op(4'd9,  16'h8000, 16'h0001, 16'h0, 1'b1, 16'h0001);
        alu_op(4'd10, 16'h0005, 16'hAAAA, 16'h0005, 1'b0, 16'h0001);
        alu_op(4'd12, 16'h0001, 16'h0000, 16'h0, 1'b1, 16'h8000);
        alu_op(4'd4,  16'h8001, 16'h0001, 16'h0, 1'b1, 16'h0003);
        alu_op(4'd1,  16'h0003, 16'h0010, 16'h0, 1'b1, 16'h000D);
        alu_op(4'd2,  16'hF0F0, 16'hFF00, 16'h0, 1'b1, 16'h0FF0);
        alu_op(4'd3,  16'hF0F0, 16'hFF00, 16'h0, 1'b1, 16'h00F0);
        alu_op(4'd5,  16'h0001, 16'h0013, 16'h0, 1'b1, 16'h0008);
        alu_op(4'd7,  16'h8000, 16'h000F, 16'h0, 1'b1, 16'h0001);
        alu_op(4'd6,  16'h0001, 16'h0001, 16'h0, 1'b1, 16'h8000);
        alu_op(4'd8,  16'h1234, 16'h1234, 16'h0, 1'b1, 16'h0001);
        alu_op(4'd9,  16'h7FFF, 16'h8000, 16'h0, 1'b1, 16'h0000);
        alu_op(4'd10, 16'h8000, 16'h7FFF, 16'h0, 1'b1, 16'h0001);
        alu_op(4'd0,  16'hFFFF, 16'h0000, 16'h0002, 1'b0, 16'h0001);
`ifndef EXECUTE_MC_DIV_EN
        issue(4'd14, 16'h0064, 16'h0007, 16'h0, 1'b1, 16'h0200, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0200, 1'b0, w);
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL divu_single got out_valid=%b busy=%b required 1 0", out_valid, busy);
        end
        alu_op(4'd15, 16'h0064, 16'h0007, 16'h0, 1'b1, 16'h0000);
`endif
        wait_drain();
    endtask

    task automatic test_branch();
        int w;
        // XOR with b=0 passes a through as the result.
        issue(4'd2, 16'hFFFE, 16'h0, 16'hFFF0, 1'b1, 16'h0100, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 16'hFFFE, 16'h00F0, 1'b1, w);
        issue(4'd2, 16'hFFFE, 16'h0, 16'hFFF0, 1'b1, 16'h0100, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 16'hFFFE, 16'h0100, 1'b0, w);
        issue(4'd2, 16'h2000, 16'h0, 16'h0004, 1'b1, 16'h0100, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 16'h2000, 16'h2004, 1'b1, w);
        issue(4'd2, 16'h2000, 16'h0, 16'h0004, 1'b1, 16'h0100, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 16'h2000, 16'h2004, 1'b1, w);
        issue(4'd2, 16'h0000, 16'h0, 16'h0004, 1'b1, 16'hFFFE, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0002, 1'b1, w);
        issue(4'd2, 16'h0000, 16'h0, 16'h0010, 1'b1, 16'h0300, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0310, 1'b1, w);
        issue(4'd2, 16'h0000, 16'h0, 16'h0010, 1'b1, 16'h0300, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0300, 1'b0, w);
        issue(4'd2, 16'h0005, 16'h0, 16'h0010, 1'b1, 16'h0300, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 16'h0005, 16'h0300, 1'b0, w);
        wait_drain();
    endtask

    task automatic test_mul();
        int w;
        issue(4'd13, 16'h0123, 16'h0010, 16'h0, 1'b1, 16'h0400, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 16'h1230, 16'h0400, 1'b0, w);
        // A second instruction is held on in_valid for the whole operation.
        set_inputs(4'd0, 16'h0001, 16'h0002, 16'h0, 1'b1, 16'h0402, 1'b0, 2'b00, 1'b0, 1'b0);
        in_valid = 1'b1;
        exp_q.push_back({1'b0, 16'h0402, 16'h0003});
        for (int k = 1; k <= W + 1; k++) begin
            @(posedge clk); #1;
            checks++;
            if (k <= W) begin
                if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1 || fsm_state !== 2'd1) begin
                    failures++;
                    $display("FAIL mul_wait cycle %0d got out_valid=%b in_ready=%b busy=%b state=%0d required 0 0 1 1",
                             k, out_valid, in_ready, busy, fsm_state);
                end
            end else begin
                if (out_valid !== 1'b1 || result !== 16'h1230 || busy !== 1'b0 || in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL mul_done got out_valid=%b result=%h busy=%b in_ready=%b required 1 1230 0 1",
                             out_valid, result, busy, in_ready);
                end
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 16'h0003) begin
            failures++;
            $display("FAIL mul_next got out_valid=%b result=%h required 1 0003", out_valid, result);
        end
        issue(4'd13, 16'hFFFF, 16'hFFFF, 16'h0, 1'b1, 16'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0001, 16'h0, 1'b0, w);
        issue(4'd13, 16'h1234, 16'hBEEF, 16'h0003, 1'b0, 16'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 16'h369C, 16'h0003, 1'b1, w);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int w;
        int stalls;
        stalls = 0;
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] x;
            x = W'(i * 16'h0111);
            issue(4'd0, x, 16'h0101, 16'h0, 1'b1, 16'h0500, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, x + 16'h0101, 16'h0500, 1'b0, w);
            stalls += w;
        end
        checks++;
        if (stalls != 0) begin
            failures++;
            $display("FAIL back_to_back got stalls=%0d required 0", stalls);
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        int w;
        out_ready = 1'b0;
        issue(4'd0, 16'h1111, 16'h2222, 16'h0, 1'b1, 16'h0600, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 16'h3333, 16'h0600, 1'b0, w);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || result !== 16'h3333 || next_pc !== 16'h0600 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold cycle %0d got out_valid=%b result=%h next_pc=%h in_ready=%b required 1 3333 0600 0",
                         k, out_valid, result, next_pc, in_ready);
            end
        end
        set_inputs(4'd1, 16'h0001, 16'h0009, 16'h0, 1'b1, 16'h0602, 1'b0, 2'b00, 1'b0, 1'b0);
        in_valid = 1'b1;
        out_ready = 1'b1;
        exp_q.push_back({1'b0, 16'h0602, 16'h0008});
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL retire_load_ready got in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 16'h0008) begin
            failures++;
            $display("FAIL retire_load got out_valid=%b result=%h required 1 0008", out_valid, result);
        end
        wait_drain();
    endtask

    task automatic test_reset_mid_mul();
        int w;
        int stale;
        issue(4'd13, 16'h00FF, 16'h00FF, 16'h0, 1'b1, 16'h0700, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, w);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 16'h0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_abort got out_valid=%b busy=%b result=%h in_ready=%b required 0 0 0000 1",
                     out_valid, busy, result, in_ready);
        end
        @(negedge clk); rst_n = 1'b1;
        stale = 0;
        for (int k = 0; k < W + 4; k++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) stale++;
        end
        checks++;
        if (stale != 0) begin
            failures++;
            $display("FAIL reset_stale got bad_cycles=%0d required 0", stale);
        end
    endtask

`ifdef EXECUTE_MC_DIV_EN
    task automatic test_div();
        int w;
        issue(4'd14, 16'd100, 16'd7, 16'h0, 1'b1, 16'h0800, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 16'd14, 16'h0800, 1'b0, w);
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0 || fsm_state !== 2'd2) begin
            failures++;
            $display("FAIL div_busy got busy=%b out_valid=%b state=%0d required 1 0 2", busy, out_valid, fsm_state);
        end
        issue(4'd15, 16'd100, 16'd7, 16'h0, 1'b1, 16'h0800, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 16'd2, 16'h0800, 1'b0, w);
        issue(4'd14, 16'h1234, 16'h0, 16'h0, 1'b1, 16'h0800, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0800, 1'b0, w);
        issue(4'd15, 16'h1234, 16'h0, 16'h0, 1'b1, 16'h0800, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h0800, 1'b0, w);
        issue(4'd14, 16'hFFFF, 16'h0001, 16'h0, 1'b1, 16'h0800, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0800, 1'b0, w);
        issue(4'd15, 16'hFFFF, 16'h00FF, 16'h0, 1'b1, 16'h0800, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0800, 1'b0, w);
        wait_drain();
    endtask
`endif

    task automatic test_random();
        int w;
        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [3:0]   o;
            logic [W-1:0] x, y, im, pc, bsel;
            logic         src, br, j, jr;
            logic [1:0]   bc;
            logic [W:0]   pcx;
            o   = 4'($urandom_range(0, 15));
            x   = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom_range(0, 65535));
            y   = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom_range(0, 65535));
            im  = 16'($urandom_range(0, 65535));
            pc  = 16'($urandom_range(0, 65535));
            src = 1'($urandom_range(0, 1));
            br  = 1'($urandom_range(0, 1));
            bc  = 2'($urandom_range(0, 3));
            j   = ($urandom_range(0, 4) == 0);
            jr  = ($urandom_range(0, 4) == 0);
            bsel = src ? y : im;
            pcx  = model_pc(x, im, pc, br, bc, j, jr);
            issue(o, x, y, im, src, pc, br, bc, j, jr, 1'b1, model_alu(o, x, bsel), pcx[W-1:0], pcx[W], w);
        end
        rand_mode = 1'b0;
        wait_drain();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_mul();
        test_back_to_back();
        test_backpressure();
`ifdef EXECUTE_MC_DIV_EN
        test_div();
`endif
        test_random();
        test_reset_mid_mul();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL final_queue got pending=%0d required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
